// File: rtl/ready_bits_collector_if.sv
// Handshake/bus bundle for ready_bits_collector: slot set/clear updates in,
// fully-ready wavefront presentation out on a valid/ack pair.
interface ready_bits_collector_if #(
    parameter int TOTAL_INFO_LENGTH = 2,
    parameter int WF_ID_LENGTH      = 6
);
    logic                         set_en;
    logic [WF_ID_LENGTH-1:0]      set_addr;
    logic [TOTAL_INFO_LENGTH-1:0] set_bits;
    logic                         clr_en;
    logic [WF_ID_LENGTH-1:0]      clr_addr;
    logic                         out_valid;
    logic [WF_ID_LENGTH-1:0]      out_wf_id;
    logic [TOTAL_INFO_LENGTH-1:0] out_bits;
    logic                         out_ack;
    logic [15:0]                  grant_count;

    modport master (
        output set_en, set_addr, set_bits, clr_en, clr_addr, out_ack,
        input  out_valid, out_wf_id, out_bits, grant_count
    );

    modport slave (
        input  set_en, set_addr, set_bits, clr_en, clr_addr, out_ack,
        output out_valid, out_wf_id, out_bits, grant_count
    );
endinterface

// File: rtl/ready_bits_collector.sv
// Per-wavefront ready-bit accumulator with a round-robin scanner presenting fully-ready
// wavefronts on valid/ack. Define READY_BITS_COLLECTOR_STATS_EN to get a saturating grant counter.
module ready_bits_collector #(
    parameter int TOTAL_INFO_LENGTH = 2,
    parameter int WF_PER_CU         = 40,
    parameter int WF_ID_LENGTH      = 6
) (
    input logic                    clk,
    input logic                    rst_n,
    ready_bits_collector_if.slave  bus
);
    typedef logic [TOTAL_INFO_LENGTH-1:0] bits_t;
    typedef logic [WF_ID_LENGTH-1:0]      wf_id_t;

    bits_t  slots [WF_PER_CU];
    wf_id_t rr_ptr;
    logic   out_valid;
    wf_id_t out_wf_id;
    bits_t  out_bits;

    logic   accept;
    logic   withdraw;
    logic   scan_found;
    wf_id_t scan_id;
    int     scan_idx;

    assign accept   = out_valid & bus.out_ack;
    assign withdraw = out_valid & ~bus.out_ack & bus.clr_en & (bus.clr_addr == out_wf_id);

    // Clear is applied before set, so a same-cycle set+clear leaves exactly set_bits.
    // Out-of-range addresses match no slot index and therefore change nothing.
    // NOTE: the slot array is reset because an empty slot must read as all zeros after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WF_PER_CU; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WF_PER_CU; i++) begin
                // NOTE: non-blocking assignment keeps every slot update based on pre-edge state.
                slots[i] <= (((bus.clr_en && bus.clr_addr == wf_id_t'(i)) ||
                              (accept && out_wf_id == wf_id_t'(i))) ? bits_t'(0) : slots[i])
                          | ((bus.set_en && bus.set_addr == wf_id_t'(i)) ? bus.set_bits : bits_t'(0));
            end
        end
    end

    // NOTE: defaults first so the search loop never infers a latch.
    always_comb begin
        scan_found = 1'b0;
        scan_id    = '0;
        scan_idx   = 0;
        for (int k = 0; k < WF_PER_CU; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= WF_PER_CU) begin
                scan_idx = scan_idx - WF_PER_CU;
            end
            if (!scan_found && (&slots[wf_id_t'(scan_idx)])) begin
                scan_found = 1'b1;
                scan_id    = wf_id_t'(scan_idx);
            end
        end
    end

    // Accept and withdraw both force a bubble so the scan sees the updated slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_wf_id <= '0;
            out_bits  <= '0;
        end else if (accept) begin
            out_valid <= 1'b0;
            rr_ptr    <= (out_wf_id == wf_id_t'(WF_PER_CU - 1)) ? wf_id_t'(0) : out_wf_id + 1'b1;
        end else if (withdraw) begin
            out_valid <= 1'b0;
        end else if (!out_valid && scan_found) begin
            out_valid <= 1'b1;
            out_wf_id <= scan_id;
            out_bits  <= slots[scan_id];
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_wf_id = out_wf_id;
    assign bus.out_bits  = out_bits;

`ifdef READY_BITS_COLLECTOR_STATS_EN
    logic [15:0] grant_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (accept && grant_count != 16'hFFFF) begin
            grant_count <= grant_count + 16'd1;
        end
    end

    assign bus.grant_count = grant_count;
`else
    assign bus.grant_count = 16'h0000;
`endif

endmodule
